// File: rtl/ni_flit_injector.sv
// Network-interface transmitter: turns core packet requests into head/body/tail
// flits and drives them over a req / on-off link into a router input port.
module ni_flit_injector #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COORD_W = 3,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned SRC_X   = 0,
  parameter int unsigned SRC_Y   = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_pkt_valid,
  output logic                o_pkt_ready,
  input  logic [COORD_W-1:0]  i_dst_x,
  input  logic [COORD_W-1:0]  i_dst_y,
  input  logic [LEN_W-1:0]    i_len,
  input  logic                i_data_valid,
  output logic                o_data_ready,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_on_off,
  output logic                o_upstream_req,
  output logic [DATA_W+1:0]   o_flit,
  output logic                o_busy,
  output logic [15:0]         o_pkt_count
);

  localparam int unsigned FLIT_W = DATA_W + 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;
  localparam logic [1:0] TYPE_HT   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   dst_x_q, dst_x_d;
  logic [COORD_W-1:0]   dst_y_q, dst_y_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic                 req_q, req_d;
  logic [FLIT_W-1:0]    flit_q, flit_d;
  logic [CNT_W-1:0]     pkt_count_q, pkt_count_d;
  logic                 busy_q, busy_d;
  logic                 pkt_ready_q, pkt_ready_d;
  logic [DATA_W-1:0]    head_payload;

  // Head payload, LSB first: len, src_y, src_x, dst_y, dst_x; upper bits zero.
  assign head_payload = DATA_W'({dst_x_q, dst_y_q, COORD_W'(SRC_X),
                                 COORD_W'(SRC_Y), len_q});

  // The receiver's on_off gates payload acceptance in the same cycle.
  assign o_data_ready = (state_q == ST_BODY) && i_on_off;

  always_comb begin
    state_d     = state_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    len_d       = len_q;
    remaining_d = remaining_q;
    req_d       = 1'b0;
    flit_d      = flit_q;
    pkt_count_d = pkt_count_q;

    case (state_q)
      ST_IDLE: begin
        if (i_pkt_valid) begin
          dst_x_d = i_dst_x;
          dst_y_d = i_dst_y;
          len_d   = i_len;
          state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (i_on_off) begin
          req_d = 1'b1;
          if (len_q == '0) begin
            flit_d      = {TYPE_HT, head_payload};
            pkt_count_d = pkt_count_q + CNT_W'(1);
            state_d     = ST_IDLE;
          end else begin
            flit_d      = {TYPE_HEAD, head_payload};
            remaining_d = len_q;
            state_d     = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (i_data_valid && i_on_off) begin
          req_d       = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            flit_d      = {TYPE_TAIL, i_data};
            pkt_count_d = pkt_count_q + CNT_W'(1);
            state_d     = ST_IDLE;
          end else begin
            flit_d = {TYPE_BODY, i_data};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    pkt_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      len_q       <= '0;
      remaining_q <= '0;
      req_q       <= 1'b0;
      flit_q      <= '0;
      pkt_count_q <= '0;
      busy_q      <= 1'b0;
      pkt_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      len_q       <= len_d;
      remaining_q <= remaining_d;
      req_q       <= req_d;
      flit_q      <= flit_d;
      pkt_count_q <= pkt_count_d;
      busy_q      <= busy_d;
      pkt_ready_q <= pkt_ready_d;
    end
  end

  assign o_upstream_req = req_q;
  assign o_flit         = flit_q;
  assign o_pkt_count    = pkt_count_q;
  assign o_busy         = busy_q;
  assign o_pkt_ready    = pkt_ready_q;

endmodule
